// File: rtl/tlight_pkg.sv
// Shared types for the actuated intersection controller: light heads,
// phase encoding, service direction and a small constant helper.
package tlight_pkg;

   typedef enum logic [2:0] {
      RED    = 3'b100,
      YELLOW = 3'b010,
      GREEN  = 3'b001
   } light_t;

   typedef enum logic [2:0] {
      ALL_RED  = 3'd0,
      WE_READY = 3'd1,
      WE_GO    = 3'd2,
      WE_STOP  = 3'd3,
      NS_READY = 3'd4,
      NS_GO    = 3'd5,
      NS_STOP  = 3'd6,
      PED_WALK = 3'd7
   } phase_t;

   typedef enum logic {
      DIR_WE = 1'b0,
      DIR_NS = 1'b1
   } dir_t;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tlight_phase_timer.sv
// Loadable saturating cycle counter. cnt_o is 0 on the first cycle of a
// phase; done_o flags the last cycle of a phase whose length is limit_i.
module tlight_phase_timer #(
   parameter int unsigned W    = 4,
   parameter int unsigned MAXV = 15
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic [W-1:0] limit_i,
   output logic [W-1:0] cnt_o,
   output logic         done_o
);

   localparam logic [W-1:0] MAXV_C = W'(MAXV);
   localparam logic [W:0]   ONE_C  = (W+1)'(1);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W:0]   cnt_plus1;

   // Restart at 0 on a phase change, otherwise count up and hold at MAXV.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (cnt_q < MAXV_C) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Compare one bit wider so cnt+1 never wraps at saturation.
   assign cnt_plus1 = {1'b0, cnt_q} + ONE_C;
   assign done_o    = (cnt_plus1 >= {1'b0, limit_i});
   assign cnt_o     = cnt_q;

endmodule

// File: rtl/tlight_scheduler.sv
// Actuated two-way intersection controller: phase FSM, latched vehicle and
// pedestrian requests, last-served direction and Moore light decode.
module tlight_scheduler
   import tlight_pkg::*;
#(
   parameter int unsigned READY_TIME  = 3,
   parameter int unsigned MIN_GREEN   = 5,
   parameter int unsigned MAX_GREEN   = 15,
   parameter int unsigned STOP_TIME   = 1,
   parameter int unsigned ALLRED_TIME = 1,
   parameter int unsigned PED_TIME    = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req_we,
   input  logic       req_ns,
   input  logic       ped_req,
   output logic [2:0] we,
   output logic [2:0] ns,
   output logic       walk,
   output logic [2:0] phase
);

   localparam int unsigned MAXP = max2(max2(max2(READY_TIME, MIN_GREEN), max2(MAX_GREEN, STOP_TIME)),
                                       max2(ALLRED_TIME, PED_TIME));
   localparam int unsigned CW   = $clog2(MAXP + 1);

   phase_t          phase_q, phase_d;
   dir_t            last_dir_q, last_dir_d;
   logic            we_pend_q, we_pend_d;
   logic            ns_pend_q, ns_pend_d;
   logic            ped_pend_q, ped_pend_d;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   limit;
   logic [CW:0]     cnt_plus1;
   logic            done;
   logic            min_ok;

   // Single timer, restarted whenever the phase is about to change.
   tlight_phase_timer #(
      .W    (CW),
      .MAXV (MAXP)
   ) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .load_i  (phase_d != phase_q),
      .limit_i (limit),
      .cnt_o   (cnt),
      .done_o  (done)
   );

   assign cnt_plus1 = {1'b0, cnt} + (CW+1)'(1);
   assign min_ok    = (cnt_plus1 >= (CW+1)'(MIN_GREEN));

   // Phase length selected for the timer; in GO it is the max-green bound.
   always_comb begin
      limit = CW'(ALLRED_TIME);
      case (phase_q)
         WE_READY, NS_READY: limit = CW'(READY_TIME);
         WE_GO, NS_GO:       limit = CW'(MAX_GREEN);
         WE_STOP, NS_STOP:   limit = CW'(STOP_TIME);
         PED_WALK:           limit = CW'(PED_TIME);
         default:            limit = CW'(ALLRED_TIME);
      endcase
   end

   // Phase state register; reset lands in ALL_RED at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= ALL_RED;
      end else begin
         phase_q <= phase_d;
      end
   end

   // Next phase: fixed-length phases advance on done, GO is actuated.
   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         ALL_RED: begin
            if (done) begin
               if (ped_pend_q)                               phase_d = PED_WALK;
               else if ((last_dir_q == DIR_NS) && we_pend_q) phase_d = WE_READY;
               else if ((last_dir_q == DIR_WE) && ns_pend_q) phase_d = NS_READY;
               else if (last_dir_q == DIR_WE)                phase_d = WE_READY;
               else                                          phase_d = NS_READY;
            end
         end
         WE_READY: if (done) phase_d = WE_GO;
         WE_GO: begin
            if ((ns_pend_q || ped_pend_q) && (done || (min_ok && !req_we))) phase_d = WE_STOP;
         end
         WE_STOP:  if (done) phase_d = ALL_RED;
         NS_READY: if (done) phase_d = NS_GO;
         NS_GO: begin
            if ((we_pend_q || ped_pend_q) && (done || (min_ok && !req_ns))) phase_d = NS_STOP;
         end
         NS_STOP:  if (done) phase_d = ALL_RED;
         PED_WALK: if (done) phase_d = ALL_RED;
         default:  phase_d = ALL_RED;
      endcase
   end

   // Moore light decode from the registered phase only.
   always_comb begin
      we   = RED;
      ns   = RED;
      walk = 1'b0;
      case (phase_q)
         WE_READY, WE_STOP: we = YELLOW;
         WE_GO:             we = GREEN;
         NS_READY, NS_STOP: ns = YELLOW;
         NS_GO:             ns = GREEN;
         PED_WALK:          walk = 1'b1;
         default: ;
      endcase
   end

   assign phase = phase_q;

   // Request latches and last direction; a clear on GO/WALK entry beats a same-edge request.
   always_comb begin
      we_pend_d  = we_pend_q  | (req_we  && (phase_q != WE_GO));
      ns_pend_d  = ns_pend_q  | (req_ns  && (phase_q != NS_GO));
      ped_pend_d = ped_pend_q | (ped_req && (phase_q != PED_WALK));
      if ((phase_q != WE_GO)    && (phase_d == WE_GO))    we_pend_d  = 1'b0;
      if ((phase_q != NS_GO)    && (phase_d == NS_GO))    ns_pend_d  = 1'b0;
      if ((phase_q != PED_WALK) && (phase_d == PED_WALK)) ped_pend_d = 1'b0;
      last_dir_d = last_dir_q;
      if ((phase_q == WE_STOP) && (phase_d == ALL_RED)) last_dir_d = DIR_WE;
      if ((phase_q == NS_STOP) && (phase_d == ALL_RED)) last_dir_d = DIR_NS;
   end

   // Request/direction registers; reset primes a WE service first.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         we_pend_q  <= 1'b1;
         ns_pend_q  <= 1'b0;
         ped_pend_q <= 1'b0;
         last_dir_q <= DIR_NS;
      end else begin
         we_pend_q  <= we_pend_d;
         ns_pend_q  <= ns_pend_d;
         ped_pend_q <= ped_pend_d;
         last_dir_q <= last_dir_d;
      end
   end

endmodule

// File: tb/tb_tlight_scheduler.sv
// Directed bench for tlight_scheduler at default parameters. Each step is
// taken 1 time unit after a rising edge; expected phases are hand-derived.
module tb_tlight_scheduler;

   localparam logic [2:0] P_ALL_RED  = 3'd0;
   localparam logic [2:0] P_WE_READY = 3'd1;
   localparam logic [2:0] P_WE_GO    = 3'd2;
   localparam logic [2:0] P_WE_STOP  = 3'd3;
   localparam logic [2:0] P_NS_READY = 3'd4;
   localparam logic [2:0] P_NS_GO    = 3'd5;
   localparam logic [2:0] P_NS_STOP  = 3'd6;
   localparam logic [2:0] P_PED_WALK = 3'd7;

   localparam logic [2:0] L_RED    = 3'b100;
   localparam logic [2:0] L_YELLOW = 3'b010;
   localparam logic [2:0] L_GREEN  = 3'b001;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_we  = 1'b0;
   logic       req_ns  = 1'b0;
   logic       ped_req = 1'b0;
   logic [2:0] we;
   logic [2:0] ns;
   logic       walk;
   logic [2:0] phase;

   int checks = 0;
   int errors = 0;

   tlight_scheduler dut (
      .clock   (clock),
      .reset_n (reset_n),
      .req_we  (req_we),
      .req_ns  (req_ns),
      .ped_req (ped_req),
      .we      (we),
      .ns      (ns),
      .walk    (walk),
      .phase   (phase)
   );

   // Clock generation.
   always #5 clock = ~clock;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [2:0] exp_we(input logic [2:0] ph);
      case (ph)
         P_WE_READY, P_WE_STOP: return L_YELLOW;
         P_WE_GO:               return L_GREEN;
         default:               return L_RED;
      endcase
   endfunction

   function automatic logic [2:0] exp_ns(input logic [2:0] ph);
      case (ph)
         P_NS_READY, P_NS_STOP: return L_YELLOW;
         P_NS_GO:               return L_GREEN;
         default:               return L_RED;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expect phase ph (and its light decode) for n consecutive cycles.
   task automatic hold(input string tag, input logic [2:0] ph, input int n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_phase"}, 32'(phase), 32'(ph));
         check({tag, "_we"},    32'(we),    32'(exp_we(ph)));
         check({tag, "_ns"},    32'(ns),    32'(exp_ns(ph)));
         check({tag, "_walk"},  32'(walk),  32'(ph == P_PED_WALK));
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      // Reset state.
      #12;
      check("rst_phase", 32'(phase), 32'(P_ALL_RED));
      check("rst_we",    32'(we),    32'(L_RED));
      check("rst_ns",    32'(ns),    32'(L_RED));
      check("rst_walk",  32'(walk),  32'(0));
      @(posedge clock); #1;
      reset_n = 1'b1;

      // No requests: first service is WE, then rest in WE_GO.
      hold("boot_allred", P_ALL_RED, 1);
      hold("boot_weready", P_WE_READY, 3);
      hold("boot_wego_rest", P_WE_GO, 40);

      // Single req_ns pulse sampled at edge k -> WE_STOP at edge k+1.
      req_ns = 1'b1;
      hold("nspulse_k", P_WE_GO, 1);
      req_ns = 1'b0;
      hold("nspulse_k1", P_WE_GO, 1);
      hold("nspulse_westop", P_WE_STOP, 1);
      hold("nspulse_allred", P_ALL_RED, 1);
      hold("nspulse_nsready", P_NS_READY, 3);
      check("nspend_cleared_in_nsgo", 32'(dut.ns_pend_q), 32'(0));
      hold("nspulse_nsgo", P_NS_GO, 6);

      // Return to WE; req_ns on the WE_GO entry edge with req_we held -> 15 cycles.
      req_we = 1'b1;
      hold("back1_nsgo", P_NS_GO, 1);
      req_we = 1'b0;
      hold("back1_nsgo_k1", P_NS_GO, 1);
      hold("back1_nsstop", P_NS_STOP, 1);
      hold("back1_allred", P_ALL_RED, 1);
      hold("back1_weready", P_WE_READY, 2);
      req_ns = 1'b1;
      req_we = 1'b1;
      hold("max_weready_last", P_WE_READY, 1);
      req_ns = 1'b0;
      hold("max_wego", P_WE_GO, 15);
      req_we = 1'b0;
      hold("max_westop", P_WE_STOP, 1);
      hold("max_allred", P_ALL_RED, 1);
      hold("max_nsready", P_NS_READY, 3);
      hold("max_nsgo_rest", P_NS_GO, 6);

      // Same again with req_we low -> 5 cycles of WE_GO.
      req_we = 1'b1;
      hold("back2_nsgo", P_NS_GO, 1);
      req_we = 1'b0;
      hold("back2_nsgo_k1", P_NS_GO, 1);
      hold("back2_nsstop", P_NS_STOP, 1);
      hold("back2_allred", P_ALL_RED, 1);
      hold("back2_weready", P_WE_READY, 2);
      req_ns = 1'b1;
      hold("min_weready_last", P_WE_READY, 1);
      req_ns = 1'b0;
      hold("min_wego", P_WE_GO, 5);
      hold("min_westop", P_WE_STOP, 1);
      hold("min_allred", P_ALL_RED, 1);
      hold("min_nsready", P_NS_READY, 3);
      hold("min_nsgo_rest", P_NS_GO, 6);

      // Back to WE, pedestrian pulse on WE_GO entry -> walk phase after 5 GO cycles.
      req_we = 1'b1;
      hold("back3_nsgo", P_NS_GO, 1);
      req_we = 1'b0;
      hold("back3_nsgo_k1", P_NS_GO, 1);
      hold("back3_nsstop", P_NS_STOP, 1);
      hold("back3_allred", P_ALL_RED, 1);
      hold("back3_weready", P_WE_READY, 2);
      ped_req = 1'b1;
      hold("ped_weready_last", P_WE_READY, 1);
      ped_req = 1'b0;
      hold("ped_wego", P_WE_GO, 5);
      hold("ped_westop", P_WE_STOP, 1);
      hold("ped_allred1", P_ALL_RED, 1);
      hold("ped_walk", P_PED_WALK, 8);
      hold("ped_allred2", P_ALL_RED, 1);
      hold("ped_weready", P_WE_READY, 3);

      // Both directions held: strict alternation, 15-cycle greens, 40-cycle period.
      req_we = 1'b1;
      req_ns = 1'b1;
      for (int c = 0; c < 2; c++) begin
         hold("alt_wego", P_WE_GO, 15);
         hold("alt_westop", P_WE_STOP, 1);
         hold("alt_allred_a", P_ALL_RED, 1);
         hold("alt_nsready", P_NS_READY, 3);
         hold("alt_nsgo", P_NS_GO, 15);
         hold("alt_nsstop", P_NS_STOP, 1);
         hold("alt_allred_b", P_ALL_RED, 1);
         hold("alt_weready", P_WE_READY, 3);
      end
      hold("pre_rst_wego", P_WE_GO, 15);
      hold("pre_rst_westop", P_WE_STOP, 1);
      hold("pre_rst_allred", P_ALL_RED, 1);
      hold("pre_rst_nsready", P_NS_READY, 3);
      hold("pre_rst_nsgo", P_NS_GO, 4);

      // Asynchronous reset mid NS_GO, between clock edges.
      #3;
      reset_n = 1'b0;
      #1;
      check("async_rst_phase", 32'(phase), 32'(P_ALL_RED));
      check("async_rst_we",    32'(we),    32'(L_RED));
      check("async_rst_ns",    32'(ns),    32'(L_RED));
      check("async_rst_walk",  32'(walk),  32'(0));
      req_we = 1'b0;
      req_ns = 1'b0;
      @(posedge clock); #1;
      check("rst_held_phase", 32'(phase), 32'(P_ALL_RED));
      reset_n = 1'b1;
      hold("restart_allred", P_ALL_RED, 1);
      hold("restart_weready", P_WE_READY, 3);
      hold("restart_wego", P_WE_GO, 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
